// File: rtl/ft_lockstep_monitor.sv
// N-way lockstep monitor: registered compare of per-core regfile write ports,
// majority vote, PC checkpointing, and the debug-halt / reset recovery sequencer.
module ft_lockstep_monitor #(
    parameter int NCORES       = 3,
    parameter int DW           = 32,
    parameter int AW           = 5,
    parameter int PCW          = 32,
    parameter int RESET_CYCLES = 4,
    parameter int TIMEOUT      = 1023,
    parameter int MAX_RETRY    = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic [NCORES-1:0]    we_i,
    input  logic [NCORES*AW-1:0] waddr_i,
    input  logic [NCORES*DW-1:0] wdata_i,
    input  logic [PCW-1:0]       pc_i,
    input  logic                 valid_instr_i,
    input  logic [NCORES-1:0]    done_i,
    output logic                 recover_o,
    output logic                 reset_o,
    output logic                 recovering_o,
    output logic                 mismatch_o,
    output logic [NCORES-1:0]    faulty_core_o,
    output logic [PCW-1:0]       checkpoint_pc_o,
    output logic [15:0]          err_count_o,
    output logic                 fatal_o
);

    localparam int TW  = 1 + AW + DW;
    localparam int TMW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int RTW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TMW-1:0] TIMER_LAST = TMW'(TIMEOUT - 1);
    localparam logic [RCW-1:0] RCNT_LAST  = RCW'(RESET_CYCLES - 1);
    localparam logic [RTW-1:0] RETRY_MAX  = RTW'(MAX_RETRY);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_RECOVER = 2'd1,
        ST_RESET   = 2'd2,
        ST_FATAL   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [RTW-1:0]    retry_q, retry_d;
    logic [TMW-1:0]    timer_q, timer_d;
    logic [RCW-1:0]    rcnt_q, rcnt_d;
    logic [PCW-1:0]    ckpt_q, ckpt_d;
    logic [NCORES-1:0] faulty_q, faulty_d;
    logic [15:0]       err_q, err_d;
    logic              mismatch_q, mismatch_d;
    logic              recover_q, recover_d;
    logic              reset_q, reset_d;
    logic              fatal_q, fatal_d;

    logic [TW-1:0]     tuple_s [NCORES];
    logic              diff_s;
    logic              mm_s;
    logic              maj_found_s;
    logic [TW-1:0]     maj_val_s;
    logic [NCORES-1:0] vote_s;

    // Build the compare tuples; address and data are masked when the write is not enabled.
    always_comb begin
        for (int k = 0; k < NCORES; k++) begin
            tuple_s[k] = we_i[k] ? {1'b1, waddr_i[k*AW +: AW], wdata_i[k*DW +: DW]} : {TW{1'b0}};
        end
    end

    // Disagreement with core 0, and the majority vote used to name the faulty cores.
    always_comb begin
        int agree;
        diff_s      = 1'b0;
        maj_found_s = 1'b0;
        maj_val_s   = tuple_s[0];
        agree       = 0;
        for (int k = 1; k < NCORES; k++) begin
            diff_s = diff_s | (tuple_s[k] != tuple_s[0]);
        end
        for (int k = 0; k < NCORES; k++) begin
            agree = 0;
            for (int j = 0; j < NCORES; j++) begin
                agree = agree + ((tuple_s[j] == tuple_s[k]) ? 1 : 0);
            end
            if ((2 * agree > NCORES) && !maj_found_s) begin
                maj_found_s = 1'b1;
                maj_val_s   = tuple_s[k];
            end else begin
                maj_found_s = maj_found_s;
            end
        end
        // Without a strict majority (always the case for two cores) every core is suspect.
        for (int k = 0; k < NCORES; k++) begin
            vote_s[k] = maj_found_s ? (tuple_s[k] != maj_val_s) : 1'b1;
        end
        mm_s = (state_q == ST_RUN) && enable_i && diff_s;
    end

    // Next-state, counters, checkpoint and registered-output computation.
    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        timer_d    = timer_q;
        rcnt_d     = rcnt_q;
        ckpt_d     = ckpt_q;
        faulty_d   = faulty_q;
        err_d      = err_q;
        mismatch_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mm_s) begin
                    mismatch_d = 1'b1;
                    faulty_d   = vote_s;
                    err_d      = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
                    if (retry_q == RETRY_MAX) begin
                        state_d = ST_FATAL;
                    end else begin
                        retry_d = retry_q + RTW'(1);
                        timer_d = {TMW{1'b0}};
                        state_d = ST_RECOVER;
                    end
                end else if (valid_instr_i) begin
                    ckpt_d  = pc_i;
                    retry_d = {RTW{1'b0}};
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RECOVER: begin
                if ((&done_i) || (timer_q == TIMER_LAST)) begin
                    rcnt_d  = {RCW{1'b0}};
                    state_d = ST_RESET;
                end else begin
                    timer_d = timer_q + TMW'(1);
                end
            end
            ST_RESET: begin
                if (rcnt_q == RCNT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    rcnt_d = rcnt_q + RCW'(1);
                end
            end
            ST_FATAL: begin
                state_d = ST_FATAL;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        recover_d = (state_d == ST_RECOVER);
        reset_d   = (state_d == ST_RESET) || (state_d == ST_FATAL);
        fatal_d   = (state_d == ST_FATAL);
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_RUN;
            retry_q    <= {RTW{1'b0}};
            timer_q    <= {TMW{1'b0}};
            rcnt_q     <= {RCW{1'b0}};
            ckpt_q     <= {PCW{1'b0}};
            faulty_q   <= {NCORES{1'b0}};
            err_q      <= 16'd0;
            mismatch_q <= 1'b0;
            recover_q  <= 1'b0;
            reset_q    <= 1'b0;
            fatal_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            retry_q    <= retry_d;
            timer_q    <= timer_d;
            rcnt_q     <= rcnt_d;
            ckpt_q     <= ckpt_d;
            faulty_q   <= faulty_d;
            err_q      <= err_d;
            mismatch_q <= mismatch_d;
            recover_q  <= recover_d;
            reset_q    <= reset_d;
            fatal_q    <= fatal_d;
        end
    end

    assign recover_o       = recover_q;
    assign recovering_o    = recover_q;
    assign reset_o         = reset_q;
    assign fatal_o         = fatal_q;
    assign mismatch_o      = mismatch_q;
    assign faulty_core_o   = faulty_q;
    assign checkpoint_pc_o = ckpt_q;
    assign err_count_o     = err_q;

endmodule
